// File: rtl/i2c_target_rx.sv
// i2c_target_rx: I2C target receive front end.
// Oversamples SCL/SDA, detects START/STOP, matches a 7-bit address, ACKs
// and delivers received data bytes on a one-cycle strobe.
// Optional read support is enabled by defining I2C_TARGET_READ_EN.
// Ports:
//   clk, reset       - system clock, synchronous active-high reset
//   scl_in, sda_in   - asynchronous bus lines
//   sda_oe           - 1 pulls SDA low (open-drain pad)
//   rx_data/rx_valid - received byte and its one-cycle strobe
//   start_det/stop_det - one-cycle bus condition strobes
//   busy             - addressed transaction in progress
//   tx_data/tx_req   - read data and its load strobe (read build only)
module i2c_target_rx #(
  parameter logic [6:0]  ADDR        = 7'h50,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy,
  input  logic [7:0] tx_data,
  output logic       tx_req
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BYTE_W = 8;

`ifdef I2C_TARGET_READ_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK_A, ST_RX, ST_ACK_D, ST_TX, ST_MACK, ST_IGNORE
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR, ST_ACK_A, ST_RX, ST_ACK_D, ST_IGNORE
  } state_e;
`endif

  state_e                   state_q, state_d;
  logic [SYNC_STAGES-1:0]   scl_sync_q, sda_sync_q;
  logic                     scl_h_q, sda_h_q;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [BYTE_W-1:0]        shift_q, shift_d;
  logic                     phase_q, phase_d;
  logic                     sda_oe_q, sda_oe_d;
  logic [BYTE_W-1:0]        rx_data_q, rx_data_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     start_det_q, start_det_d;
  logic                     stop_det_q, stop_det_d;
  logic                     busy_q, busy_d;
  logic                     tx_req_q, tx_req_d;
  logic                     rw_ok;

  logic scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise = scl_s & ~scl_h_q;
  assign scl_fall = ~scl_s & scl_h_q;
  // SDA edges count as START/STOP only while SCL is stable high.
  assign start_c  = scl_s & scl_h_q & sda_h_q & ~sda_s;
  assign stop_c   = scl_s & scl_h_q & ~sda_h_q & sda_s;

`ifdef I2C_TARGET_READ_EN
  logic rw_q, rw_d;
  assign rw_ok  = 1'b1;
  assign tx_req = tx_req_q;
`else
  // Reads are not served: R/W=1 is left unacknowledged.
  logic unused_tx;
  assign rw_ok     = ~sda_s;
  assign tx_req    = 1'b0;
  assign unused_tx = ^{tx_data, tx_req_q};
`endif

  // Synchronizers plus history flop; reset to bus-idle level.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_h_q    <= 1'b1;
      sda_h_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      scl_h_q    <= scl_s;
      sda_h_q    <= sda_s;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      phase_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      start_det_q <= 1'b0;
      stop_det_q  <= 1'b0;
      busy_q      <= 1'b0;
      tx_req_q    <= 1'b0;
`ifdef I2C_TARGET_READ_EN
      rw_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      phase_q     <= phase_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      start_det_q <= start_det_d;
      stop_det_q  <= stop_det_d;
      busy_q      <= busy_d;
      tx_req_q    <= tx_req_d;
`ifdef I2C_TARGET_READ_EN
      rw_q        <= rw_d;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    phase_d     = phase_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    start_det_d = 1'b0;
    stop_det_d  = 1'b0;
    tx_req_d    = 1'b0;
`ifdef I2C_TARGET_READ_EN
    rw_d        = rw_q;
`endif
    if (start_c) begin
      state_d     = ST_ADDR;
      cnt_d       = '0;
      phase_d     = 1'b0;
      sda_oe_d    = 1'b0;
      start_det_d = 1'b1;
    end else if (stop_c) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      phase_d    = 1'b0;
      sda_oe_d   = 1'b0;
      stop_det_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: sda_oe_d = 1'b0;
        ST_ADDR: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            phase_d = 1'b0;
`ifdef I2C_TARGET_READ_EN
            rw_d    = sda_s;
`endif
            state_d = (shift_q[6:0] == ADDR && rw_ok) ? ST_ACK_A : ST_IGNORE;
          end
        end
        // First SCL fall pulls SDA for the ACK slot, the second releases it.
        ST_ACK_A, ST_ACK_D: if (scl_fall) begin
          if (!phase_q) begin
            sda_oe_d = 1'b1;
            phase_d  = 1'b1;
          end else begin
            phase_d  = 1'b0;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
            state_d  = ST_RX;
`ifdef I2C_TARGET_READ_EN
            if (state_q == ST_ACK_A && rw_q) begin
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[7];
              tx_req_d = 1'b1;
              state_d  = ST_TX;
            end
`endif
          end
        end
        ST_RX: if (scl_rise) begin
          shift_d = {shift_q[6:0], sda_s};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(7)) begin
            rx_data_d  = {shift_q[6:0], sda_s};
            rx_valid_d = 1'b1;
            phase_d    = 1'b0;
            state_d    = ST_ACK_D;
          end
        end
`ifdef I2C_TARGET_READ_EN
        ST_TX: if (scl_fall) begin
          if (cnt_q == CNT_W'(7)) begin
            sda_oe_d = 1'b0;
            phase_d  = 1'b0;
            state_d  = ST_MACK;
          end else begin
            cnt_d    = cnt_q + CNT_W'(1);
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end
        end
        // phase_q marks a master ACK; the following fall reloads the shifter.
        ST_MACK: begin
          if (scl_rise) begin
            if (sda_s) state_d = ST_IGNORE;
            else       phase_d = 1'b1;
          end else if (scl_fall && phase_q) begin
            shift_d  = tx_data;
            sda_oe_d = ~tx_data[7];
            tx_req_d = 1'b1;
            cnt_d    = '0;
            phase_d  = 1'b0;
            state_d  = ST_TX;
          end
        end
`endif
        ST_IGNORE: sda_oe_d = 1'b0;
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE) && (state_d != ST_ADDR) && (state_d != ST_IGNORE);
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign start_det = start_det_q;
  assign stop_det  = stop_det_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Directed bench for i2c_target_rx: bit-banged I2C master over an
// open-drain SDA model, event counters on the DUT strobes.
module tb_i2c_target_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m, sda_m;
  logic [7:0] tx_data;
  logic       sda_oe, rx_valid, start_det, stop_det, busy, tx_req;
  logic [7:0] rx_data;
  wire        sda_bus = sda_m & ~sda_oe;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int rx_cnt = 0, start_cnt = 0, stop_cnt = 0, txreq_cnt = 0, oe_cnt = 0;
  logic [7:0] rx_log[$];

  i2c_target_rx #(.ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .scl_in(scl_m), .sda_in(sda_bus),
    .sda_oe(sda_oe), .rx_data(rx_data), .rx_valid(rx_valid),
    .start_det(start_det), .stop_det(stop_det), .busy(busy),
    .tx_data(tx_data), .tx_req(tx_req)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        rx_cnt++;
        rx_log.push_back(rx_data);
      end
      if (start_det) start_cnt++;
      if (stop_det)  stop_cnt++;
      if (tx_req)    txreq_cnt++;
      if (sda_oe)    oe_cnt++;
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_w(input logic b);
    sda_m = b; wclk(4); scl_m = 1'b1; wclk(8); scl_m = 1'b0; wclk(4);
  endtask

  // Master-released clock; returns SDA level seen mid-high.
  task automatic clk_r(output logic b);
    sda_m = 1'b1; wclk(4); scl_m = 1'b1; wclk(4); b = sda_bus; wclk(4);
    scl_m = 1'b0; wclk(4);
  endtask

  task automatic send_byte(input logic [7:0] v, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) bit_w(v[i]);
    clk_r(s);
    acked = ~s;
  endtask

  task automatic do_start;
    sda_m = 1'b1; wclk(4); scl_m = 1'b1; wclk(8); sda_m = 1'b0; wclk(8);
    scl_m = 1'b0; wclk(4);
  endtask

  task automatic do_stop;
    sda_m = 1'b0; wclk(4); scl_m = 1'b1; wclk(8); sda_m = 1'b1; wclk(8);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_oe"},   sda_oe, 1'b0);
    check_eq({tag, "_data"}, rx_data, 8'h00);
    check_eq({tag, "_strb"}, {rx_valid, start_det, stop_det, tx_req}, 4'b0000);
    check_eq({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] rd;
    int         s0, r0, p0, o0, q0, t0;

    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1; tx_data = 8'hC3;
    wclk(3);
    check_reset_outs("rst");
    reset = 1'b0;
    wclk(4);

    // Single write 0xAA to 0x50.
    s0 = start_cnt; r0 = rx_cnt; p0 = stop_cnt; q0 = rx_log.size();
    do_start;
    check_eq("t1_start", start_cnt - s0, 1);
    send_byte(8'hA0, ack);
    check_eq("t1_addr_ack", ack, 1'b1);
    check_eq("t1_busy", busy, 1'b1);
    send_byte(8'hAA, ack);
    check_eq("t1_data_ack", ack, 1'b1);
    check_eq("t1_rx_cnt", rx_cnt - r0, 1);
    check_eq("t1_rx_data", rx_log[q0], 8'hAA);
    check_eq("t1_rx_port", rx_data, 8'hAA);
    do_stop;
    check_eq("t1_stop", stop_cnt - p0, 1);
    check_eq("t1_busy_end", busy, 1'b0);

    // Address 0x51 is ignored.
    r0 = rx_cnt; p0 = stop_cnt; o0 = oe_cnt;
    do_start;
    send_byte(8'hA2, ack);
    check_eq("t2_addr_nack", ack, 1'b0);
    check_eq("t2_busy", busy, 1'b0);
    send_byte(8'h55, ack);
    check_eq("t2_data_nack", ack, 1'b0);
    do_stop;
    check_eq("t2_rx_cnt", rx_cnt - r0, 0);
    check_eq("t2_oe", oe_cnt - o0, 0);
    check_eq("t2_stop", stop_cnt - p0, 1);

    // Two data bytes.
    r0 = rx_cnt; q0 = rx_log.size();
    do_start;
    send_byte(8'hA0, ack);
    send_byte(8'h12, ack);
    check_eq("t3_ack1", ack, 1'b1);
    send_byte(8'h34, ack);
    check_eq("t3_ack2", ack, 1'b1);
    do_stop;
    check_eq("t3_rx_cnt", rx_cnt - r0, 2);
    check_eq("t3_byte0", rx_log[q0], 8'h12);
    check_eq("t3_byte1", rx_log[q0 + 1], 8'h34);

    // Repeated START abandons a partial byte.
    s0 = start_cnt; r0 = rx_cnt; q0 = rx_log.size();
    do_start;
    send_byte(8'hA0, ack);
    bit_w(1'b1); bit_w(1'b0); bit_w(1'b1); bit_w(1'b1);
    do_start;
    send_byte(8'hA0, ack);
    check_eq("t4_readdr_ack", ack, 1'b1);
    send_byte(8'h5A, ack);
    do_stop;
    check_eq("t4_start", start_cnt - s0, 2);
    check_eq("t4_rx_cnt", rx_cnt - r0, 1);
    check_eq("t4_rx_data", rx_log[q0], 8'h5A);

    // Reset mid-address, then recovery on a new START.
    r0 = rx_cnt;
    do_start;
    bit_w(1'b1); bit_w(1'b0); bit_w(1'b1); bit_w(1'b0);
    reset = 1'b1; wclk(1);
    check_reset_outs("t5_rst");
    reset = 1'b0;
    bit_w(1'b0); bit_w(1'b0); bit_w(1'b0); bit_w(1'b0);
    clk_r(rd[0]);
    check_eq("t5_no_ack", rd[0], 1'b1);
    send_byte(8'hAA, ack);
    check_eq("t5_rx_none", rx_cnt - r0, 0);
    do_stop;
    do_start;
    send_byte(8'hA0, ack);
    check_eq("t5_resume_ack", ack, 1'b1);
    do_stop;

    // Read request.
    t0 = txreq_cnt;
    do_start;
    send_byte(8'hA1, ack);
`ifdef I2C_TARGET_READ_EN
    check_eq("t6_addr_ack", ack, 1'b1);
    for (int i = 7; i >= 0; i--) clk_r(rd[i]);
    clk_r(ack);
    check_eq("t6_rd_data", rd, 8'hC3);
    check_eq("t6_tx_req", txreq_cnt - t0, 1);
    check_eq("t6_busy_nack", busy, 1'b0);
    check_eq("t6_oe_rel", sda_oe, 1'b0);
`else
    check_eq("t6_addr_nack", ack, 1'b0);
    check_eq("t6_busy", busy, 1'b0);
    for (int i = 7; i >= 0; i--) clk_r(rd[i]);
    check_eq("t6_bus_idle", rd, 8'hFF);
    check_eq("t6_tx_req", txreq_cnt - t0, 0);
`endif
    do_stop;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
